serial_sample_deserializer: RTL and testbench
=============================================

Name: serial_sample_deserializer

Overview:
Upstream feeder for the 12-bit two's-complement to floating-point converter stage. Receives samples over a 3-wire serial link (sclk, cs_n, sdi), MSB first. Synchronizes the link into the system clock domain, validates frame length, and presents each complete sample on a 12-bit parallel bus under a valid/ready handshake. The converter's D input connects directly to d_out.

Parameters:
WIDTH, 12, bits per frame and width of d_out
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (minimum 2)

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst  in  1  asynchronous reset, active-high
sclk  in  1  serial bit clock, asynchronous to clk, period at least 4 clk
cs_n  in  1  frame select, active low, asynchronous
sdi  in  1  serial data; valid around the sclk rising edge
d_out  out  WIDTH  captured sample; feeds converter D
d_valid  out  1  d_out holds an unconsumed sample
d_ready  in  1  consumer accepts d_out when d_valid and d_ready are both high
frame_err  out  1  one-clk pulse: frame ended with a bit count other than WIDTH
overrun  out  1  one-clk pulse: good frame dropped because the output register was occupied

Behaviour:
- Reset (async assert; release is synchronous to clk): d_out=0, d_valid=0, frame_err=0, overrun=0, state=IDLE, bit counter=0, shift register=0. Synchronizers reset to idle levels: sclk=0, cs_n=1, sdi=0.
- Synchronization: sclk, cs_n and sdi each pass through SYNC_STAGES flops; equal depth keeps them aligned. Edge detection compares the synchronized value with a one-cycle-delayed copy.
- A bit is sampled on a synchronized sclk rise while synchronized cs_n=0: shift left, insert sdi at LSB, increment counter (saturating at WIDTH+1).
- FSM:
  - IDLE: wait for a synchronized cs_n fall; on it clear counter and shift register, go to SHIFT. A cs_n that is low at reset release is ignored until it has been seen high.
  - SHIFT: count bits. On cs_n rise: if counter==WIDTH go to COMMIT, else pulse frame_err and go to IDLE.
  - COMMIT: single cycle, then IDLE. If d_valid==0 or d_ready==1: d_out<=shift register, d_valid<=1. Otherwise pulse overrun; d_out and d_valid are unchanged and the new sample is discarded.
- Frames with more than WIDTH bits set frame_err at cs_n rise; no commit.
- Handshake: d_valid stays high and d_out stays stable until a cycle with d_valid&&d_ready. On that edge d_valid<=0, unless the same cycle is COMMIT, in which case the new sample loads and d_valid stays 1.
- Latency: d_valid rises on the clk edge ending the COMMIT cycle. COMMIT is the cycle after synchronized cs_n rise detection, which is SYNC_STAGES+1 clk after raw cs_n rises.
- sclk edges while cs_n is high are ignored. A cs_n glitch shorter than 1 clk may be missed; this is out of spec.
- Reset mid-frame: the partial frame is lost and no frame_err is raised. Capture resumes only after cs_n has been high and then falls.
- frame_err and overrun are never asserted in the same cycle.

Test Plan:
1. Frame 12'h7FF MSB first, d_ready=0 -> d_out=12'h7FF, d_valid=1 held. Assert d_ready for 1 clk -> d_valid=0 next edge; d_out stays 12'h7FF.
2. Frame 12'h800 with d_ready tied 1 -> d_valid high for exactly 1 clk, d_out=12'h800. Exactly SYNC_STAGES+2 clk from raw cs_n rise to the d_valid rise.
3. Short frame of 7 bits, then long frame of 13 bits -> one frame_err pulse for each; d_valid remains 0; d_out unchanged (0 after reset).
4. Frames 12'h123 then 12'h456, d_ready=0 throughout -> d_out=12'h123, one overrun pulse at the second COMMIT. Then d_ready=1 -> handshake, d_valid=0; 12'h456 never appears.
5. d_valid=1 holding 12'hABC, d_ready=1 exactly in the COMMIT cycle of frame 12'h00F -> d_out=12'h00F, d_valid stays 1, no overrun.
6. rst pulse after 6 bits of a frame with cs_n held low -> all outputs 0 and no captures until cs_n is high. Then a fresh frame 12'hFFF -> d_out=12'hFFF, d_valid=1, frame_err never pulses.

Source files
------------

// File: rtl/serial_sample_deserializer_if.sv
// ==========================================================================
// serial_sample_deserializer_if: serial link inputs and parallel sample bus
// Rev 1.0
// ==========================================================================
`default_nettype none

interface serial_sample_deserializer_if #(
  parameter int WIDTH = 12
);
  logic             sclk;
  logic             cs_n;
  logic             sdi;
  logic [WIDTH-1:0] d_out;
  logic             d_valid;
  logic             d_ready;
  logic             frame_err;
  logic             overrun;

  modport slave (
    input  sclk, cs_n, sdi, d_ready,
    output d_out, d_valid, frame_err, overrun
  );

  modport master (
    output sclk, cs_n, sdi, d_ready,
    input  d_out, d_valid, frame_err, overrun
  );
endinterface

`default_nettype wire

// File: rtl/serial_sample_deserializer.sv
// ==========================================================================
// serial_sample_deserializer: synchronizes a 3-wire MSB-first serial link
// and presents each WIDTH-bit frame on a valid/ready bus.  Rev 1.0
// ==========================================================================
`default_nettype none

module serial_sample_deserializer #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_sample_deserializer_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic [SYNC_STAGES-1:0] live_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic                   armed_q;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [WIDTH-1:0]       shreg_q;
  logic [WIDTH-1:0]       dout_q;
  logic                   dvalid_q;
  logic                   ferr_q;
  logic                   ovr_q;

  logic sclk_s;
  logic cs_s;
  logic sdi_s;
  logic sclk_rise;
  logic cs_fall;
  logic cs_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  // A fall only counts once cs_n has genuinely been observed high since reset
  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise   = cs_s & ~cs_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sdi_sync_q  <= '0;
      live_q      <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
      // live_q marks when the synchronizer outputs reflect real inputs, not reset values
      live_q      <= {live_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      armed_q     <= armed_q | (live_q[SYNC_STAGES-1] & cs_s);
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;

      if (dvalid_q && bus.d_ready) begin
        dvalid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            if (cnt_q == CNT_W'(WIDTH)) begin
              state_q <= COMMIT;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else if (sclk_rise && !cs_s) begin
            shreg_q <= {shreg_q[WIDTH-2:0], sdi_s};
            if (cnt_q != CNT_W'(WIDTH + 1)) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        COMMIT: begin
          // A same-cycle consume frees the register, so the new sample may load
          if (!dvalid_q || bus.d_ready) begin
            dout_q   <= shreg_q;
            dvalid_q <= 1'b1;
          end else begin
            ovr_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.d_out     = dout_q;
  assign bus.d_valid   = dvalid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_sample_deserializer.sv
// ==========================================================================
// tb_serial_sample_deserializer: directed and randomized frames against a
// frame-level reference model.  Rev 1.0
// ==========================================================================
`default_nettype none

module tb_serial_sample_deserializer;

  localparam int WIDTH = 12;
  localparam int SYNC  = 2;
  localparam int WIN   = SYNC + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_sample_deserializer_if #(.WIDTH(WIDTH)) bus ();

  serial_sample_deserializer #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  int          n_ferr;
  int          n_ovr;
  int          n_both;
  int          rise_at;
  int          hi_cycles;
  logic [11:0] out_at_rise;

  logic [11:0] m_out;
  logic        m_valid;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bits(input logic [15:0] v, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      bus.sdi  = v[i];
      bus.sclk = 1'b0;
      clk_n(3);
      bus.sclk = 1'b1;
      clk_n(3);
    end
    bus.sclk = 1'b0;
    clk_n(3);
  endtask

  task automatic frame(input logic [15:0] v, input int len);
    bus.cs_n = 1'b0;
    clk_n(3);
    bits(v, len);
  endtask

  // Raises cs_n and watches the outputs for a fixed window.
  task automatic end_frame(input int cycles);
    logic prev_v;
    n_ferr = 0; n_ovr = 0; n_both = 0; rise_at = 0; hi_cycles = 0; out_at_rise = '0;
    prev_v = bus.d_valid;
    bus.cs_n = 1'b1;
    for (int c = 1; c <= cycles; c++) begin
      @(posedge clk);
      #1;
      if (bus.frame_err) n_ferr++;
      if (bus.overrun) n_ovr++;
      if (bus.frame_err && bus.overrun) n_both++;
      if (bus.d_valid) hi_cycles++;
      if (bus.d_valid && !prev_v && rise_at == 0) begin
        rise_at = c;
        out_at_rise = bus.d_out;
      end
      prev_v = bus.d_valid;
    end
  endtask

  initial begin
    int          len;
    logic [15:0] data;
    logic        r;
    int          exp_ferr;
    int          exp_ovr;

    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.sdi = 1'b0; bus.d_ready = 1'b0;
    clk_n(3);
    check("reset_dout", bus.d_out, 0);
    check("reset_dvalid", bus.d_valid, 0);
    check("reset_ferr", bus.frame_err, 0);
    check("reset_ovr", bus.overrun, 0);
    rst = 1'b0;
    clk_n(6);

    // Short and long frames
    frame(16'h0055, 7);
    end_frame(WIN);
    check("short_ferr", n_ferr, 1);
    check("short_valid", hi_cycles, 0);
    check("short_dout", bus.d_out, 0);
    frame(16'h1ABC, 13);
    end_frame(WIN);
    check("long_ferr", n_ferr, 1);
    check("long_valid", hi_cycles, 0);
    check("long_dout", bus.d_out, 0);

    // Capture and hold, then a one-cycle consume
    frame(16'h07FF, 12);
    end_frame(WIN);
    check("t1_dout", bus.d_out, 12'h7FF);
    check("t1_dvalid", bus.d_valid, 1);
    check("t1_ferr", n_ferr, 0);
    bus.d_ready = 1'b1;
    clk_n(1);
    bus.d_ready = 1'b0;
    check("t1_consumed", bus.d_valid, 0);
    check("t1_dout_hold", bus.d_out, 12'h7FF);

    // Latency with d_ready tied high
    bus.d_ready = 1'b1;
    frame(16'h0800, 12);
    end_frame(WIN);
    bus.d_ready = 1'b0;
    check("t2_latency", rise_at, SYNC + 2);
    check("t2_hi_cycles", hi_cycles, 1);
    check("t2_dout", out_at_rise, 12'h800);

    // Overrun
    frame(16'h0123, 12);
    end_frame(WIN);
    check("t4_first_dout", bus.d_out, 12'h123);
    check("t4_first_ovr", n_ovr, 0);
    frame(16'h0456, 12);
    end_frame(WIN);
    check("t4_ovr", n_ovr, 1);
    check("t4_both", n_both, 0);
    check("t4_dout_kept", bus.d_out, 12'h123);
    bus.d_ready = 1'b1;
    clk_n(1);
    bus.d_ready = 1'b0;
    check("t4_consumed", bus.d_valid, 0);
    clk_n(5);
    check("t4_no_456", bus.d_out, 12'h123);

    // Consume in the COMMIT cycle of the next frame
    frame(16'h0ABC, 12);
    end_frame(WIN);
    check("t5_hold_abc", bus.d_out, 12'hABC);
    frame(16'h000F, 12);
    bus.cs_n = 1'b1;
    clk_n(SYNC + 1);
    bus.d_ready = 1'b1;
    clk_n(1);
    bus.d_ready = 1'b0;
    check("t5_dout", bus.d_out, 12'h00F);
    check("t5_dvalid", bus.d_valid, 1);
    check("t5_ovr", bus.overrun, 0);
    clk_n(5);
    check("t5_dvalid_held", bus.d_valid, 1);

    // Reset mid-frame
    bus.cs_n = 1'b0;
    clk_n(3);
    bits(16'h002A, 6);
    rst = 1'b1;
    #1;
    check("t6_rst_dout", bus.d_out, 0);
    check("t6_rst_dvalid", bus.d_valid, 0);
    clk_n(2);
    rst = 1'b0;
    clk_n(2);
    bits(16'h0FFF, 12);
    end_frame(WIN);
    check("t6_no_capture", hi_cycles, 0);
    check("t6_no_ferr", n_ferr, 0);
    frame(16'h0FFF, 12);
    end_frame(WIN);
    check("t6_dout", bus.d_out, 12'hFFF);
    check("t6_dvalid", bus.d_valid, 1);
    check("t6_ferr", n_ferr, 0);

    bus.d_ready = 1'b1;
    clk_n(1);
    bus.d_ready = 1'b0;
    m_out   = 12'hFFF;
    m_valid = 1'b0;

    // Randomized frames against the frame-level model
    for (int k = 0; k < 14; k++) begin
      len  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : WIDTH;
      data = 16'($urandom) & 16'((32'd1 << len) - 1);
      r    = 1'($urandom_range(0, 1));
      bus.d_ready = r;
      if (r) m_valid = 1'b0;
      exp_ferr = (len != WIDTH) ? 1 : 0;
      exp_ovr  = 0;
      if (len == WIDTH) begin
        if (!m_valid) begin
          m_out   = data[11:0];
          m_valid = 1'b1;
        end else begin
          exp_ovr = 1;
        end
      end
      if (r) m_valid = 1'b0;
      frame(data, len);
      end_frame(WIN);
      bus.d_ready = 1'b0;
      check($sformatf("rnd%0d_dout", k), bus.d_out, m_out);
      check($sformatf("rnd%0d_dvalid", k), bus.d_valid, m_valid);
      check($sformatf("rnd%0d_ferr", k), n_ferr, exp_ferr);
      check($sformatf("rnd%0d_ovr", k), n_ovr, exp_ovr);
      check($sformatf("rnd%0d_both", k), n_both, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire
